strength_bus_resolver: RTL and testbench
========================================

# strength_bus_resolver

Cycle-based model of a multi-driver net with IEEE 1800 strength resolution, for the signal-strength feature suite. N drivers each present a value and a drive strength; the block resolves the net each clock into a 4-state value plus resolved strength, optionally holds charge like a `trireg` with timed decay, and flags contention and illegal driver strengths. It is the parametrised successor to the single-net strength checks: configurable driver count, net kind (wire/wand/wor) and charge-keeper behaviour.

## Interface
- `N_DRV`, 4: number of drivers, 2..16.
- `NET_KIND`, `NK_WIRE`: `NK_WIRE`, `NK_WAND` or `NK_WOR`; sets the equal-strength conflict rule.
- `KEEPER`, 1: 1 = undriven net holds charge (`trireg`); 0 = undriven net resolves to Z.
- `CHARGE_STR`, `S_MEDIUM`: strength of held charge; `S_SMALL`, `S_MEDIUM` or `S_LARGE` only.
- `DECAY_CYC`, 8: cycles of held charge before decaying to X; 0 = never decays.
- `CNT_W`, 8: contention counter width.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `drv_val` input N_DRV: value driven by each driver.
- `drv_str` input 3*N_DRV: strength code per driver.
- `res_val` output 2: resolved 4-state value (`V0`, `V1`, `VX`, `VZ`).
- `res_str` output 3: resolved strength code.
- `contention` output 1: resolved cycle was an equal-strength 0/1 conflict on `NK_WIRE`.
- `cont_cnt` output CNT_W: saturating count of contention cycles.
- `illegal_str` output 1: sticky; any driver used a charge strength.

## Operation
- Strength codes, ascending: 0 highz, 1 small, 2 medium, 3 weak, 4 large, 5 pull, 6 strong, 7 supply.
- Legal driver strengths: 0, 3, 5, 6, 7. Codes 1, 2, 4 set `illegal_str`; that driver is treated as highz.
- s0 = max strength over drivers with `drv_val`=0; s1 = max strength over drivers with `drv_val`=1.
- s1>s0: `V1`@s1. s0>s1: `V0`@s0.
- s0=s1≠0: `NK_WIRE` gives `VX`@s0 and asserts `contention`; `NK_WAND` gives `V0`@s0; `NK_WOR` gives `V1`@s1.
- s0=s1=0 (undriven):
  - `KEEPER`=0: `VZ`@0.
  - `KEEPER`=1: hold last driven value (`V0`/`V1`/`VX`) at `CHARGE_STR`. Decay counter starts at 0 on the first undriven cycle. When it reaches `DECAY_CYC`, value becomes `VX`@`CHARGE_STR` and is held until driven.
  - If no driven value since reset: `VZ`@0.
- Any driven cycle reloads the held value and clears the decay counter.
- `cont_cnt` increments on each `contention` cycle and saturates at all-ones.
- State machine (keeper only):
  - `ST_FLOAT`: nothing held since reset.
  - `ST_DRIVEN`: net driven this cycle.
  - `ST_HOLD`: charge held, counting.
  - `ST_DECAYED`: charge decayed to X.
  - `ST_FLOAT`/`ST_HOLD`/`ST_DECAYED` go to `ST_DRIVEN` on any driven input. `ST_DRIVEN` goes to `ST_HOLD` on undriven. `ST_HOLD` goes to `ST_DECAYED` at the count limit.

## Timing
- Registered outputs, latency 1: inputs sampled at edge k appear on the outputs after edge k.
- Decay: last driven at edge k; X appears after edge k+`DECAY_CYC`+1.
- Reset values: `res_val`=`VZ`, `res_str`=0, `contention`=0, `cont_cnt`=0, `illegal_str`=0, state `ST_FLOAT`, decay counter 0.
- `rst` high mid-hold discards the held charge. `rst` has priority over all inputs on the same edge.
- An illegal code and a contention on the same cycle update both flags.
- Undriven and a simultaneous re-drive is not possible; the cycle is either driven or not.

## Structure
- `strength_pkg`:
  - `strength_e` with all eight codes.
  - `val4_e` (`V0`/`V1`/`VX`/`VZ`).
  - `net_kind_e`.
  - `keeper_st_e`.
  - function `is_drive_strength()`.
- Sub-module `strength_reduce`: combinational, N_DRV inputs, outputs s0, s1 and the illegal flag. The top block holds the resolve rules, keeper FSM and counters.
- Elaboration check: `CHARGE_STR` must be in {1, 2, 4}.

## Test plan
- Drivers 0 strong (6) and 1 pull (5) -> `V0`@6 one cycle later; `contention`=0.
- Drivers 0 pull and 1 pull, `NK_WIRE` -> `VX`@5, `contention`=1, `cont_cnt` 1; same stimulus under `NK_WAND` -> `V0`@5, under `NK_WOR` -> `V1`@5.
- `KEEPER`=1, `DECAY_CYC`=3: drive 1 strong, then all highz -> `V1`@2 for 3 cycles, then `VX`@2; re-drive 0 weak -> `V0`@3.
- Driver strength 4 (large) with value 1, other drivers highz -> `illegal_str` set and stays set; net treated as undriven (`VZ`@0 after reset).
- 2^`CNT_W`+5 contention cycles -> `cont_cnt` stays at all-ones.
- `rst` asserted during `ST_HOLD` -> next cycle `VZ`@0, counters and flags cleared.

Source files
------------

// File: rtl/strength_pkg.sv
// Shared types for the strength-resolving net model.
//   strength_e   : IEEE 1800 strength codes, ascending (highz .. supply)
//   val4_e       : resolved 4-state net value
//   net_kind_e   : equal-strength conflict rule (wire / wand / wor)
//   keeper_st_e  : charge-keeper state
//   is_drive_strength() : 1 when a code may legally be used by a driver
package strength_pkg;

  typedef enum logic [2:0] {
    S_HIGHZ  = 3'd0,
    S_SMALL  = 3'd1,
    S_MEDIUM = 3'd2,
    S_WEAK   = 3'd3,
    S_LARGE  = 3'd4,
    S_PULL   = 3'd5,
    S_STRONG = 3'd6,
    S_SUPPLY = 3'd7
  } strength_e;

  typedef enum logic [1:0] {
    V0 = 2'd0,
    V1 = 2'd1,
    VX = 2'd2,
    VZ = 2'd3
  } val4_e;

  typedef enum logic [1:0] {
    NK_WIRE = 2'd0,
    NK_WAND = 2'd1,
    NK_WOR  = 2'd2
  } net_kind_e;

  typedef enum logic [1:0] {
    ST_FLOAT   = 2'd0,
    ST_DRIVEN  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DECAYED = 2'd3
  } keeper_st_e;

  // Charge strengths (small, medium, large) belong to trireg nets only;
  // highz is legal and simply means "not driving".
  function automatic logic is_drive_strength(input logic [2:0] s);
    case (s)
      S_SMALL, S_MEDIUM, S_LARGE: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/strength_reduce.sv
// Combinational strength reduction across all drivers.
//   drv_val [N_DRV]   : value per driver
//   drv_str [3*N_DRV] : strength code per driver (driver i at [3i+2:3i])
//   s0, s1            : strongest strength driving 0 / driving 1
//   illegal           : some driver used a charge strength this cycle
// Drivers with a charge strength contribute nothing (treated as highz).
module strength_reduce
  import strength_pkg::*;
#(
  parameter int N_DRV = 4
) (
  input  logic [N_DRV-1:0]   drv_val,
  input  logic [3*N_DRV-1:0] drv_str,
  output logic [2:0]         s0,
  output logic [2:0]         s1,
  output logic               illegal
);

  logic [2:0] s;

  always_comb begin
    s0      = '0;
    s1      = '0;
    illegal = 1'b0;
    s       = '0;
    for (int i = 0; i < N_DRV; i++) begin
      s = drv_str[3*i +: 3];
      if (!is_drive_strength(s)) begin
        illegal = 1'b1;
      end else if (drv_val[i]) begin
        if (s > s1) s1 = s;
      end else begin
        if (s > s0) s0 = s;
      end
    end
  end

endmodule

// File: rtl/strength_bus_resolver.sv
// Cycle-based multi-driver net with strength resolution and optional
// trireg-style charge keeping with timed decay to X.
//   clk, rst     : clock, synchronous active-high reset
//   drv_val      : value per driver (N_DRV)
//   drv_str      : 3-bit strength code per driver (3*N_DRV)
//   res_val      : resolved value (V0/V1/VX/VZ), registered
//   res_str      : resolved strength code, registered
//   contention   : equal-strength 0/1 fight on a plain wire this cycle
//   cont_cnt     : saturating count of contention cycles
//   illegal_str  : sticky, some driver used a charge strength
module strength_bus_resolver
  import strength_pkg::*;
#(
  parameter int        N_DRV      = 4,
  parameter net_kind_e NET_KIND   = NK_WIRE,
  parameter bit        KEEPER     = 1'b1,
  parameter strength_e CHARGE_STR = S_MEDIUM,
  parameter int        DECAY_CYC  = 8,
  parameter int        CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_DRV-1:0]     drv_val,
  input  logic [3*N_DRV-1:0]   drv_str,
  output logic [1:0]           res_val,
  output logic [2:0]           res_str,
  output logic                 contention,
  output logic [CNT_W-1:0]     cont_cnt,
  output logic                 illegal_str
);

  if (!(CHARGE_STR == S_SMALL || CHARGE_STR == S_MEDIUM || CHARGE_STR == S_LARGE))
    begin : g_bad_charge
      $error("strength_bus_resolver: CHARGE_STR must be small, medium or large");
    end
  if (N_DRV < 2 || N_DRV > 16) begin : g_bad_ndrv
    $error("strength_bus_resolver: N_DRV must be 2..16");
  end

  // Decay counter runs 0 .. DECAY_CYC-1 while charge is held.
  localparam int DCNT_W = (DECAY_CYC > 2) ? $clog2(DECAY_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'((DECAY_CYC > 0) ? DECAY_CYC - 1 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [2:0]        s0_p0, s1_p0;
  logic              illegal_p0, driven_p0;
  keeper_st_e        state, state_nxt;
  logic [DCNT_W-1:0] dcnt, dcnt_nxt;
  val4_e             held, held_nxt;
  val4_e             val_nxt;
  logic [2:0]        str_nxt;
  logic              cont_nxt;

  strength_reduce #(.N_DRV(N_DRV)) u_reduce (
    .drv_val (drv_val),
    .drv_str (drv_str),
    .s0      (s0_p0),
    .s1      (s1_p0),
    .illegal (illegal_p0)
  );

  assign driven_p0 = (s0_p0 != 3'd0) || (s1_p0 != 3'd0);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    held_nxt  = held;
    val_nxt   = VZ;
    str_nxt   = S_HIGHZ;
    cont_nxt  = 1'b0;
    if (driven_p0) begin
      if (s1_p0 > s0_p0) begin
        val_nxt = V1;
        str_nxt = s1_p0;
      end else if (s0_p0 > s1_p0) begin
        val_nxt = V0;
        str_nxt = s0_p0;
      end else begin
        str_nxt = s0_p0;
        case (NET_KIND)
          NK_WAND: val_nxt = V0;
          NK_WOR:  val_nxt = V1;
          default: begin
            val_nxt  = VX;
            cont_nxt = 1'b1;
          end
        endcase
      end
      held_nxt  = val_nxt;
      dcnt_nxt  = '0;
      state_nxt = ST_DRIVEN;
    end else if (KEEPER) begin
      case (state)
        ST_DRIVEN: begin
          val_nxt   = held;
          str_nxt   = CHARGE_STR;
          dcnt_nxt  = '0;
          state_nxt = ST_HOLD;
        end
        ST_HOLD: begin
          str_nxt = CHARGE_STR;
          if (DECAY_CYC == 0) begin
            val_nxt = held;
          end else if (dcnt == DCNT_LAST) begin
            val_nxt   = VX;
            state_nxt = ST_DECAYED;
          end else begin
            val_nxt  = held;
            dcnt_nxt = dcnt + 1'b1;
          end
        end
        ST_DECAYED: begin
          val_nxt = VX;
          str_nxt = CHARGE_STR;
        end
        default: state_nxt = ST_FLOAT;
      endcase
    end else begin
      state_nxt = ST_FLOAT;
    end
  end

  // Stage boundary: resolved net and status registered (latency 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FLOAT;
      dcnt        <= '0;
      res_val     <= VZ;
      res_str     <= '0;
      contention  <= 1'b0;
      cont_cnt    <= '0;
      illegal_str <= 1'b0;
    end else begin
      state       <= state_nxt;
      dcnt        <= dcnt_nxt;
      res_val     <= val_nxt;
      res_str     <= str_nxt;
      contention  <= cont_nxt;
      if (cont_nxt) cont_cnt <= sat_inc(cont_cnt);
      illegal_str <= illegal_str | illegal_p0;
    end
  end

  // Held charge value is only consulted outside ST_FLOAT, so it needs no reset.
  always_ff @(posedge clk) begin
    held <= held_nxt;
  end

endmodule

// File: tb/tb_strength_bus_resolver.sv
module tb_strength_bus_resolver;
  import strength_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  drv_val = '0;
  logic [11:0] drv_str = '0;

  logic [1:0] w_val, a_val, o_val;
  logic [2:0] w_str, a_str, o_str;
  logic       w_cont, a_cont, o_cont;
  logic [3:0] w_cnt;
  logic [7:0] a_cnt, o_cnt;
  logic       w_ill, a_ill, o_ill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  strength_bus_resolver #(.N_DRV(4), .NET_KIND(NK_WIRE), .KEEPER(1'b1),
    .CHARGE_STR(S_MEDIUM), .DECAY_CYC(3), .CNT_W(4)) u_wire (
    .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str(drv_str),
    .res_val(w_val), .res_str(w_str), .contention(w_cont),
    .cont_cnt(w_cnt), .illegal_str(w_ill));

  strength_bus_resolver #(.N_DRV(4), .NET_KIND(NK_WAND), .KEEPER(1'b0)) u_wand (
    .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str(drv_str),
    .res_val(a_val), .res_str(a_str), .contention(a_cont),
    .cont_cnt(a_cnt), .illegal_str(a_ill));

  strength_bus_resolver #(.N_DRV(4), .NET_KIND(NK_WOR), .KEEPER(1'b0)) u_wor (
    .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str(drv_str),
    .res_val(o_val), .res_str(o_str), .contention(o_cont),
    .cont_cnt(o_cnt), .illegal_str(o_ill));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] v, input logic [11:0] s);
    @(negedge clk);
    rst     = r;
    drv_val = v;
    drv_str = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_net(input string tag, input logic [1:0] v, input logic [2:0] s);
    chk({tag, "_val"}, 32'(w_val), 32'(v));
    chk({tag, "_str"}, 32'(w_str), 32'(s));
  endtask

  initial begin
    // reset
    step(1'b1, 4'b0000, 12'd0);
    step(1'b1, 4'b0000, 12'd0);
    chk_net("rst", VZ, 3'd0);
    chk("rst_cont", 32'(w_cont), 32'd0);
    chk("rst_cnt", 32'(w_cnt), 32'd0);
    chk("rst_ill", 32'(w_ill), 32'd0);

    // d0=0 strong, d1=1 pull
    step(1'b0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd6});
    chk_net("strong_vs_pull", V0, 3'd6);
    chk("strong_vs_pull_cont", 32'(w_cont), 32'd0);

    // d0=0 pull, d1=1 pull
    step(1'b0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd5});
    chk_net("wire_tie", VX, 3'd5);
    chk("wire_tie_cont", 32'(w_cont), 32'd1);
    chk("wire_tie_cnt", 32'(w_cnt), 32'd1);
    chk("wand_tie_val", 32'(a_val), 32'(V0));
    chk("wand_tie_str", 32'(a_str), 32'd5);
    chk("wand_tie_cont", 32'(a_cont), 32'd0);
    chk("wor_tie_val", 32'(o_val), 32'(V1));
    chk("wor_tie_str", 32'(o_str), 32'd5);

    // drive 1 strong, then release: hold at medium for 3 cycles, then X
    step(1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6});
    chk_net("drive1", V1, 3'd6);
    chk("drive1_cont", 32'(w_cont), 32'd0);
    chk("drive1_cnt", 32'(w_cnt), 32'd1);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("hold1", V1, 3'd2);
    chk("wand_undriven_val", 32'(a_val), 32'(VZ));
    chk("wand_undriven_str", 32'(a_str), 32'd0);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("hold2", V1, 3'd2);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("hold3", V1, 3'd2);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("decay", VX, 3'd2);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("decay_stays", VX, 3'd2);
    step(1'b0, 4'b0000, {3'd0, 3'd0, 3'd0, 3'd3});
    chk_net("redrive0_weak", V0, 3'd3);

    // illegal strength after reset
    step(1'b1, 4'b0000, 12'd0);
    chk_net("rst2", VZ, 3'd0);
    chk("rst2_cnt", 32'(w_cnt), 32'd0);
    step(1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd4});
    chk_net("illegal_large", VZ, 3'd0);
    chk("illegal_set", 32'(w_ill), 32'd1);
    chk("illegal_set_wand", 32'(a_ill), 32'd1);
    step(1'b0, 4'b0000, 12'd0);
    chk("illegal_sticky", 32'(w_ill), 32'd1);
    chk_net("illegal_float", VZ, 3'd0);
    // contention together with an illegal medium driver (ignored)
    step(1'b0, 4'b0110, {3'd0, 3'd2, 3'd5, 3'd5});
    chk_net("cont_illegal", VX, 3'd5);
    chk("cont_illegal_cont", 32'(w_cont), 32'd1);
    chk("cont_illegal_cnt", 32'(w_cnt), 32'd1);
    chk("cont_illegal_ill", 32'(w_ill), 32'd1);

    // reset during hold discards charge and clears flags
    step(1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6});
    step(1'b0, 4'b0000, 12'd0);
    chk_net("pre_rst_hold", V1, 3'd2);
    step(1'b1, 4'b0000, 12'd0);
    chk_net("rst_hold", VZ, 3'd0);
    chk("rst_hold_cnt", 32'(w_cnt), 32'd0);
    chk("rst_hold_ill", 32'(w_ill), 32'd0);
    chk("rst_hold_cont", 32'(w_cont), 32'd0);
    step(1'b0, 4'b0000, 12'd0);
    chk_net("post_rst_float", VZ, 3'd0);

    // saturation of the 4-bit contention counter
    for (int i = 1; i <= 21; i++) begin
      step(1'b0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd5});
      if (i == 14) chk("cnt_14", 32'(w_cnt), 32'd14);
      if (i == 15) chk("cnt_15", 32'(w_cnt), 32'd15);
    end
    chk("cnt_sat", 32'(w_cnt), 32'd15);
    chk("cnt_sat_cont", 32'(w_cont), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
